seg_scan_sequencer: RTL and testbench
=====================================

# seg_scan_sequencer

Time-multiplexing sequencer for a 4-digit display: steps a 2-bit digit index through 0..3 on a programmable slot period and produces the select index `W[1:0]` and enable `En` that drive the downstream 2:4 digit-select decoder directly. It also presents the selected 4-bit nibble for the segment path. A blanking interval at the start of every slot keeps the decoder disabled while the index changes, which prevents ghosting. Optional digit masking is supported.

## Interface
- `SCAN_DIV`, 50000: slot length in clock cycles; legal range BLANK_CYCLES+1 .. 2^DIV_WIDTH.
- `BLANK_CYCLES`, 8: cycles at the start of each slot with `En` low; must be ≥1.
- `DIV_WIDTH`, 16: width of the internal slot counter.

- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `Run`  in  1  scan enable; level-sensitive.
- `Data`  in  16  four nibbles; digit k = `Data[4k+3:4k]`.
- `Mask`  in  4  `Mask[k]`=1 blanks digit k.
- `W`  out  2  digit index to the decoder.
- `En`  out  1  decoder enable.
- `Nibble`  out  4  value of the current digit.
- `Frame`  out  1  one-cycle pulse on wrap from digit 3 to digit 0.

## Operation
- All outputs are registered. Reset values: `W`=00, `En`=0, `Nibble`=0, `Frame`=0. Internal state after reset: IDLE, counter 0.
- States:
  - IDLE: `En`=0, `W` held. When `Run`=1, go to BLANK with `W`=00 and counter=0.
  - BLANK: `En`=0. Moves to SHOW when counter reaches BLANK_CYCLES.
  - SHOW: `En`=1 unless the latched mask bit is set, in which case `En`=0.
  - At the end of SHOW (counter = SCAN_DIV-1), return to BLANK with counter=0 and `W`=`W`+1 mod 4 (11 wraps to 00).
- Slot start, meaning each BLANK entry including the first: latch `Nibble` ← `Data[4W+3:4W]` for the new `W`, and latch `Mask[W]`. Changes to `Data` or `Mask` during a slot have no effect until the next slot start.
- `Frame`=1 only in the cycle when `W` goes from 11 to 00. There is no pulse on the initial start from IDLE.
- `Run`=0 in any state: go to IDLE at the next edge, with `En`=0, `Frame`=0, and `W` and `Nibble` held. A later `Run`=1 always restarts at digit 00.
- `Rst` asserted in any state forces the reset values immediately, with no clock required.

## Timing
- Slot length is exactly SCAN_DIV cycles:
  - cycles 0..BLANK_CYCLES-1 of the slot: `En`=0;
  - cycles BLANK_CYCLES..SCAN_DIV-1: `En`=1 if the digit is unmasked.
- `W` and `Nibble` change only on the first cycle of a slot, while `En`=0. `W` never changes while `En`=1.
- Start latency: 1 cycle after `Run` is sampled high, `W`=00 and BLANK begins. `En` first rises BLANK_CYCLES cycles later.
- Full frame: 4×SCAN_DIV cycles. `Frame` period equals the frame length.
- Stop latency: `En` goes low on the first edge after `Run` is sampled low.

## Configuration
- `SCAN_SKIP_MASKED_EN` defined: a slot whose latched mask bit is 1 lasts only BLANK_CYCLES cycles, then `W` advances. If all four digits are masked, `W` cycles every BLANK_CYCLES cycles with `En`=0 throughout, and `Frame` still pulses on each wrap.
- Not defined: a masked slot lasts the full SCAN_DIV cycles with `En`=0, so the frame period is constant.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYCLES=2.
- Normal scan: `Rst` pulse, then `Run`=1, `Mask`=0, `Data`=16'hA5C3. Expect `W` = 0,1,2,3 for 8 cycles each. In every slot `En` is 0 for 2 cycles, then 1 for 6. `Nibble` = 3, C, 5, A.
- Frame pulse: run 40 cycles. `Frame`=1 for exactly one cycle, coincident with the `W` change from 11 to 00, 32 cycles after start. No pulse at start.
- Masking: `Mask`=4'b0100.
  - Without the macro: slot 2 lasts 8 cycles with `En`=0.
  - With `SCAN_SKIP_MASKED_EN`: slot 2 lasts 2 cycles and the frame is 26 cycles.
- Mid-slot data change: change `Data` from 16'hA5C3 to 16'h0000 at cycle 4 of slot 1. `Nibble` stays C until slot 2, which shows 0.
- Async reset: assert `Rst` at cycle 5 of slot 2, between clock edges. `W`, `En`, `Nibble`, `Frame` go to 0 without a clock edge. After release with `Run`=1, scanning restarts at `W`=00.
- Stop/restart: drop `Run` at cycle 6 of slot 3. At the next edge `En`=0 and `W` holds 11. Reassert `Run`: `W`=00 and BLANK for 2 cycles, with no `Frame` pulse.

Source files
------------

// File: rtl/seg_scan_sequencer.sv
// seg_scan_sequencer: 4-digit display scan sequencer with per-slot blanking; define SCAN_SKIP_MASKED_EN to shorten masked slots to the blank interval
module seg_scan_sequencer #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter int DIV_WIDTH    = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Run,
  input  logic [15:0] Data,
  input  logic [3:0]  Mask,
  output logic [1:0]  W,
  output logic        En,
  output logic [3:0]  Nibble,
  output logic        Frame
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;
  localparam logic [DIV_WIDTH-1:0] SLOT_LAST  = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           w_q, w_d, w_n;
  logic                 en_q, en_d;
  logic [3:0]           nib_q, nib_d;
  logic                 mask_q, mask_d;
  logic                 frame_q, frame_d;
  logic                 skip, adv;

`ifdef SCAN_SKIP_MASKED_EN
  assign skip = mask_q;
`else
  assign skip = 1'b0;
`endif

  // Slot sequencing: a new slot starts from IDLE or at the end of the current slot
  always_comb begin
    adv     = (state_q == SHOW && cnt_q == SLOT_LAST) || (state_q == BLANK && skip && cnt_q == BLANK_LAST);
    w_n     = (state_q == IDLE) ? 2'd0 : w_q + 2'd1;
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    w_d     = w_q;
    en_d    = en_q;
    nib_d   = nib_q;
    mask_d  = mask_q;
    frame_d = 1'b0;
    if (!Run) begin
      state_d = IDLE;
      cnt_d   = '0;
      en_d    = 1'b0;
    end else if (state_q == IDLE || adv) begin
      state_d = BLANK;
      cnt_d   = '0;
      w_d     = w_n;
      nib_d   = Data[{w_n, 2'b00} +: 4];
      mask_d  = Mask[w_n];
      en_d    = 1'b0;
      frame_d = adv && w_q == 2'd3;
    end else if (state_q == BLANK && cnt_q == BLANK_LAST) begin
      state_d = SHOW;
      en_d    = ~mask_q;
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= 2'd0;
      en_q    <= 1'b0;
      nib_q   <= 4'd0;
      mask_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      en_q    <= en_d;
      nib_q   <= nib_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
    end
  end

  assign W      = w_q;
  assign En     = en_q;
  assign Nibble = nib_q;
  assign Frame  = frame_q;
endmodule

// File: tb/tb_seg_scan_sequencer.sv
// tb_seg_scan_sequencer: directed checks of scan timing, frame pulse, masking, data latching, reset and stop/restart
module tb_seg_scan_sequencer;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Run = 1'b0;
  logic [15:0] Data = 16'hA5C3;
  logic [3:0]  Mask = 4'b0000;
  logic [1:0]  W;
  logic        En;
  logic [3:0]  Nibble;
  logic        Frame;
  int          vec = 0;
  int          errs = 0;

  seg_scan_sequencer #(.SCAN_DIV(8), .BLANK_CYCLES(2), .DIV_WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Data(Data), .Mask(Mask),
    .W(W), .En(En), .Nibble(Nibble), .Frame(Frame)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic restart;
    Rst = 1'b1;
    #2;
    Rst = 1'b0;
    Run = 1'b1;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    #3;
    vec++;
    if ({W, En, Nibble, Frame} !== 8'd0) begin
      errs++;
      $display("FAIL reset_async got W=%0d En=%0b Nib=%h Fr=%0b want all 0", W, En, Nibble, Frame);
    end
    Run = 1'b1;
    tick();
    vec++;
    if ({W, En, Nibble, Frame} !== 8'd0) begin
      errs++;
      $display("FAIL reset_held got W=%0d En=%0b Nib=%h Fr=%0b want all 0", W, En, Nibble, Frame);
    end
  endtask

  task automatic test_normal_scan;
    logic [15:0] d = 16'hA5C3;
    logic [1:0]  ew;
    logic        een;
    Data = d;
    Mask = 4'b0000;
    restart();
    for (int c = 0; c < 32; c++) begin
      tick();
      ew  = 2'(c / 8);
      een = (c % 8) >= 2;
      vec++;
      if (W !== ew || En !== een || Nibble !== d[{ew, 2'b00} +: 4] || Frame !== 1'b0) begin
        errs++;
        $display("FAIL scan c=%0d got W=%0d En=%0b Nib=%h Fr=%0b want W=%0d En=%0b Nib=%h Fr=0",
                 c, W, En, Nibble, Frame, ew, een, d[{ew, 2'b00} +: 4]);
      end
    end
  endtask

  task automatic test_frame;
    int pulses = 0;
    Data = 16'hA5C3;
    Mask = 4'b0000;
    restart();
    for (int c = 0; c < 40; c++) begin
      tick();
      pulses += int'(Frame);
      vec++;
      if (Frame !== (c == 32)) begin
        errs++;
        $display("FAIL frame c=%0d got Fr=%0b want %0b", c, Frame, c == 32);
      end
      if (c == 31 || c == 32) begin
        vec++;
        if (W !== ((c == 31) ? 2'd3 : 2'd0)) begin
          errs++;
          $display("FAIL frame_wrap c=%0d got W=%0d want %0d", c, W, (c == 31) ? 3 : 0);
        end
      end
    end
    vec++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL frame_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_mask;
    logic [15:0] d = 16'hA5C3;
    logic [3:0]  m = 4'b0100;
    int          w = 0;
    int          pos = 0;
    int          len;
    logic        een;
    logic        efr;
    Data = d;
    Mask = m;
    restart();
    for (int c = 0; c < 36; c++) begin
      tick();
      een = !m[w] && pos >= 2;
      efr = (c > 0) && pos == 0 && w == 0;
      vec++;
      if (W !== 2'(w) || En !== een || Nibble !== d[4*w +: 4] || Frame !== efr) begin
        errs++;
        $display("FAIL mask c=%0d got W=%0d En=%0b Nib=%h Fr=%0b want W=%0d En=%0b Nib=%h Fr=%0b",
                 c, W, En, Nibble, Frame, w, een, d[4*w +: 4], efr);
      end
`ifdef SCAN_SKIP_MASKED_EN
      len = m[w] ? 2 : 8;
`else
      len = 8;
`endif
      pos++;
      if (pos == len) begin
        pos = 0;
        w = (w + 1) % 4;
      end
    end
    Mask = 4'b0000;
  endtask

  task automatic test_data_change;
    Data = 16'hA5C3;
    Mask = 4'b0000;
    restart();
    for (int c = 0; c < 26; c++) begin
      tick();
      if (c == 12) Data = 16'h0000;
      if (c >= 8) begin
        vec++;
        if (Nibble !== ((c < 16) ? 4'hC : 4'h0)) begin
          errs++;
          $display("FAIL data_change c=%0d got Nib=%h want %h", c, Nibble, (c < 16) ? 4'hC : 4'h0);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    Data = 16'hA5C3;
    Mask = 4'b0000;
    restart();
    for (int c = 0; c < 22; c++) tick();
    vec++;
    if (W !== 2'd2 || En !== 1'b1 || Nibble !== 4'h5) begin
      errs++;
      $display("FAIL areset_pre got W=%0d En=%0b Nib=%h want W=2 En=1 Nib=5", W, En, Nibble);
    end
    #2;
    Rst = 1'b1;
    #1;
    vec++;
    if ({W, En, Nibble, Frame} !== 8'd0) begin
      errs++;
      $display("FAIL areset_now got W=%0d En=%0b Nib=%h Fr=%0b want all 0", W, En, Nibble, Frame);
    end
    Rst = 1'b0;
    tick();
    vec++;
    if (W !== 2'd0 || En !== 1'b0 || Nibble !== 4'h3 || Frame !== 1'b0) begin
      errs++;
      $display("FAIL areset_restart got W=%0d En=%0b Nib=%h Fr=%0b want W=0 En=0 Nib=3 Fr=0", W, En, Nibble, Frame);
    end
    tick();
    tick();
    vec++;
    if (En !== 1'b1 || W !== 2'd0) begin
      errs++;
      $display("FAIL areset_show got W=%0d En=%0b want W=0 En=1", W, En);
    end
  endtask

  task automatic test_stop_restart;
    Data = 16'hA5C3;
    Mask = 4'b0000;
    restart();
    for (int c = 0; c < 31; c++) tick();
    vec++;
    if (W !== 2'd3 || En !== 1'b1) begin
      errs++;
      $display("FAIL stop_pre got W=%0d En=%0b want W=3 En=1", W, En);
    end
    Run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vec++;
      if (W !== 2'd3 || En !== 1'b0 || Nibble !== 4'hA || Frame !== 1'b0) begin
        errs++;
        $display("FAIL stop k=%0d got W=%0d En=%0b Nib=%h Fr=%0b want W=3 En=0 Nib=A Fr=0", k, W, En, Nibble, Frame);
      end
    end
    Run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vec++;
      if (W !== 2'd0 || En !== (c >= 2) || Nibble !== 4'h3 || Frame !== 1'b0) begin
        errs++;
        $display("FAIL restart c=%0d got W=%0d En=%0b Nib=%h Fr=%0b want W=0 En=%0b Nib=3 Fr=0", c, W, En, Nibble, Frame, c >= 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_scan();
    test_frame();
    test_mask();
    test_data_change();
    test_async_reset();
    test_stop_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
